ghost_motion_executor: RTL

Motion back-end for one ghost. It accepts the next-position and direction requests produced by a ghost control block, paces them with a move tick, and validates each step against the tile wall map. It then commits the legal position and feeds the committed pos_x/pos_y back as the controller's x/y inputs. It sits between the ghost controller and the renderer/collision logic and is the single owner of the ghost's actual position.

---
 rtl/ghost_motion_executor.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ghost_motion_executor.sv
`default_nettype none
// ============================================================================
//  Module   : ghost_motion_executor
//  Brief    : Paces ghost position requests with a move tick, checks each step
//             against the tile wall map and commits the legal position.
//             Optional: define GHOST_TUNNEL_EN for horizontal tunnel wrap.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif
`ifndef TILE_ROW_NUM
`define TILE_ROW_NUM 24
`endif
`ifndef TILE_COL_NUM
`define TILE_COL_NUM 32
`endif
`ifndef DIR_UP
`define DIR_UP    2'b00
`define DIR_DOWN  2'b01
`define DIR_LEFT  2'b10
`define DIR_RIGHT 2'b11
`endif

module ghost_motion_executor #(
    parameter int TICK_DIV  = 2500000,
    parameter int TILE_SIZE = 20,
    parameter int SPAWN_X   = 340,
    parameter int SPAWN_Y   = 240
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        enable,
    input  logic                                        respawn,
    input  logic [$clog2(`WIDTH)-1:0]                   req_x,
    input  logic [$clog2(`HEIGHT)-1:0]                  req_y,
    input  logic [1:0]                                  req_dir,
    input  logic [`TILE_ROW_NUM*`TILE_COL_NUM-1:0]      tilemap_walls,
    output logic [$clog2(`WIDTH)-1:0]                   pos_x,
    output logic [$clog2(`HEIGHT)-1:0]                  pos_y,
    output logic [1:0]                                  dir,
    output logic                                        step_pulse,
    output logic                                        blocked
);

    localparam int c_X_W     = $clog2(`WIDTH);
    localparam int c_Y_W     = $clog2(`HEIGHT);
    localparam int c_N_TILES = `TILE_ROW_NUM * `TILE_COL_NUM;
    localparam int c_IDX_W   = $clog2(c_N_TILES);
    localparam int c_CNT_W   = $clog2(TICK_DIV);

    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_X_W-1:0]     c_SPAWN_X  = c_X_W'(SPAWN_X);
    localparam logic [c_Y_W-1:0]     c_SPAWN_Y  = c_Y_W'(SPAWN_Y);
    localparam logic [c_X_W-1:0]     c_TILE_X   = c_X_W'(TILE_SIZE);
    localparam logic [c_Y_W-1:0]     c_TILE_Y   = c_Y_W'(TILE_SIZE);
    localparam logic signed [c_X_W:0] c_DX_LIM  = (c_X_W+1)'(TILE_SIZE);
    localparam logic signed [c_Y_W:0] c_DY_LIM  = (c_Y_W+1)'(TILE_SIZE);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_CHECK  = 2'd1;
    localparam logic [1:0] c_S_COMMIT = 2'd2;

    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_state;
    logic [c_X_W-1:0]   r_lx;
    logic [c_Y_W-1:0]   r_ly;
    logic [1:0]         r_ldir;
    logic [c_X_W-1:0]   r_pos_x;
    logic [c_Y_W-1:0]   r_pos_y;
    logic [1:0]         r_dir;
    logic               r_blocked;
    logic               r_step;

    logic               w_tick;
    logic               w_in_x;
    logic               w_in_y;
    logic signed [c_X_W:0] w_dx;
    logic signed [c_Y_W:0] w_dy;
    logic               w_step_ok;
    logic [c_X_W-1:0]   w_tx;
    logic [c_X_W-1:0]   w_col;
    logic [c_Y_W-1:0]   w_row;
    logic [31:0]        w_idx;
    logic               w_wall;
    logic               w_legal_norm;
    logic               w_legal;

    assign w_tick = enable && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (respawn) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_tick ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

    // Differences are one bit wider than the coordinate so that an
    // underflowed request (0 - 20 -> 1004) reads as a large step.
    assign w_in_x = 32'(r_lx) < `WIDTH;
    assign w_in_y = 32'(r_ly) < `HEIGHT;
    assign w_dx   = $signed({1'b0, r_lx}) - $signed({1'b0, r_pos_x});
    assign w_dy   = $signed({1'b0, r_ly}) - $signed({1'b0, r_pos_y});

    assign w_step_ok = ((w_dx == '0) || (w_dy == '0))
                    && (w_dx <= c_DX_LIM) && (w_dx >= -c_DX_LIM)
                    && (w_dy <= c_DY_LIM) && (w_dy >= -c_DY_LIM);

`ifdef GHOST_TUNNEL_EN
    logic w_wrap_l;
    logic w_wrap_r;
    logic w_legal_wrap;

    assign w_wrap_l = !w_in_x && (r_pos_x == '0) && (r_ldir == `DIR_LEFT);
    assign w_wrap_r = !w_in_x && (r_pos_x == c_X_W'(`WIDTH - TILE_SIZE))
                   && (r_ldir == `DIR_RIGHT);
    assign w_tx     = w_wrap_l ? c_X_W'(`WIDTH - TILE_SIZE) :
                      w_wrap_r ? '0 : r_lx;
    assign w_legal_wrap = w_in_y && (r_ly == r_pos_y) && !w_wall;
    assign w_legal  = (w_wrap_l || w_wrap_r) ? w_legal_wrap : w_legal_norm;
`else
    assign w_tx     = r_lx;
    assign w_legal  = w_legal_norm;
`endif

    // Out-of-map indices read as walls; the range check rejects them anyway.
    assign w_col  = w_tx / c_TILE_X;
    assign w_row  = r_ly / c_TILE_Y;
    assign w_idx  = 32'(w_row) * `TILE_COL_NUM + 32'(w_col);
    assign w_wall = (w_idx < c_N_TILES) ? tilemap_walls[w_idx[c_IDX_W-1:0]] : 1'b1;

    assign w_legal_norm = w_in_x && w_in_y && w_step_ok && !w_wall;

    // The verdict is taken at the end of CHECK so the new position and the
    // step pulse are both visible during the COMMIT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_S_IDLE;
            r_lx      <= '0;
            r_ly      <= '0;
            r_ldir    <= `DIR_UP;
            r_pos_x   <= c_SPAWN_X;
            r_pos_y   <= c_SPAWN_Y;
            r_dir     <= `DIR_UP;
            r_blocked <= 1'b0;
            r_step    <= 1'b0;
        end else if (respawn) begin
            r_state   <= c_S_IDLE;
            r_pos_x   <= c_SPAWN_X;
            r_pos_y   <= c_SPAWN_Y;
            r_dir     <= `DIR_UP;
            r_blocked <= 1'b0;
            r_step    <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_step <= 1'b0;
                    if (w_tick) begin
                        r_lx    <= req_x;
                        r_ly    <= req_y;
                        r_ldir  <= req_dir;
                        r_state <= c_S_CHECK;
                    end
                end
                c_S_CHECK: begin
                    if (w_legal) begin
                        r_pos_x   <= w_tx;
                        r_pos_y   <= r_ly;
                        r_dir     <= r_ldir;
                        r_blocked <= 1'b0;
                    end else begin
                        r_blocked <= 1'b1;
                    end
                    r_step  <= 1'b1;
                    r_state <= c_S_COMMIT;
                end
                c_S_COMMIT: begin
                    r_step  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_step  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign pos_x      = r_pos_x;
    assign pos_y      = r_pos_y;
    assign dir        = r_dir;
    assign blocked    = r_blocked;
    // A respawn coinciding with COMMIT suppresses the pulse in that same cycle.
    assign step_pulse = r_step & ~respawn;

endmodule

`default_nettype wire
